// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: runs a valid/ready request and response handshake
// to data memory, flags misaligned and timed-out accesses, and pulses completion.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_en,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              err_sticky,
  output logic [DATA_W-1:0] rdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit_c;
  logic             accept_c;
  logic             busy_d;
  logic             done_d;
  logic             err_d;
  logic             valid_d;

  // The current cycle is the TIMEOUT-th one spent in REQ/WAIT_RESP.
  assign tmo_hit_c = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign accept_c  = (state_q == S_IDLE) && mem_en && (is_load ^ is_store) &&
                     (addr[1:0] == 2'b00);

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_busy  <= busy_d;
      mem_done  <= done_d;
      mem_err   <= err_d;
      req_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          if (!is_load && !is_store)      state_d = S_DONE;
          else if (is_load && is_store)   state_d = S_ERR;
          else if (addr[1:0] != 2'b00)    state_d = S_ERR;
          else                            state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready)      state_d = S_WAIT;
        else if (tmo_hit_c) state_d = S_ERR;
      end
      S_WAIT: begin
        if (resp_valid)     state_d = S_DONE;
        else if (tmo_hit_c) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE) || (state_d == S_ERR);
    err_d   = (state_d == S_ERR);
    valid_d = (state_d == S_REQ);
  end

  // Request latch, timeout counter, load data capture and sticky error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      tmo_cnt    <= '0;
      rdata      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept_c) begin
        req_addr  <= addr;
        req_wdata <= wdata;
        req_we    <= is_store;
        tmo_cnt   <= '0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if ((state_q == S_WAIT) && resp_valid && !req_we) begin
        rdata <= resp_rdata;
      end
      if ((state_d == S_ERR) || ((state_q != S_IDLE) && mem_en)) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a default instance plus a TIMEOUT=4 instance
// sharing the same stimulus.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mem_en;
  logic              is_load;
  logic              is_store;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  logic              mem_busy, mem_done, mem_err, err_sticky;
  logic [DATA_W-1:0] rdata;
  logic              req_valid, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              t_busy, t_done, t_err, t_sticky;
  logic [DATA_W-1:0] t_rdata;
  logic              t_req_valid, t_req_we;
  logic [ADDR_W-1:0] t_req_addr;
  logic [DATA_W-1:0] t_req_wdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_unit u_dut (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .is_load(is_load),
    .is_store(is_store), .addr(addr), .wdata(wdata), .mem_busy(mem_busy),
    .mem_done(mem_done), .mem_err(mem_err), .err_sticky(err_sticky), .rdata(rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
  );

  mem_access_unit #(.TIMEOUT(4)) u_tmo (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .is_load(is_load),
    .is_store(is_store), .addr(addr), .wdata(wdata), .mem_busy(t_busy),
    .mem_done(t_done), .mem_err(t_err), .err_sticky(t_sticky), .rdata(t_rdata),
    .req_valid(t_req_valid), .req_ready(req_ready), .req_we(t_req_we),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic strobe(input logic ld, input logic st, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    mem_en = 1'b1; is_load = ld; is_store = st; addr = a; wdata = d;
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; idle_inputs(); addr = '0; wdata = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    step(); step();
    check("rst_busy", 64'(mem_busy), 64'd0);
    check("rst_done", 64'(mem_done), 64'd0);
    check("rst_valid", 64'(req_valid), 64'd0);
    check("rst_sticky", 64'(err_sticky), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    reset_n = 1'b1;
    step();

    // Nominal load at 0x100.
    strobe(1'b1, 1'b0, 32'h100, 32'h0);
    step(); idle_inputs();
    check("ld_req_valid", 64'(req_valid), 64'd1);
    check("ld_req_addr", 64'(req_addr), 64'h100);
    check("ld_req_we", 64'(req_we), 64'd0);
    check("ld_done_c1", 64'(mem_done), 64'd0);
    req_ready = 1'b1;
    step(); req_ready = 1'b0;
    check("ld_valid_c2", 64'(req_valid), 64'd0);
    check("ld_busy_c2", 64'(mem_busy), 64'd1);
    resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
    step(); resp_valid = 1'b0;
    check("ld_done_c3", 64'(mem_done), 64'd1);
    check("ld_err_c3", 64'(mem_err), 64'd0);
    check("ld_rdata", 64'(rdata), 64'hDEADBEEF);
    step();
    check("ld_done_c4", 64'(mem_done), 64'd0);
    check("ld_busy_c4", 64'(mem_busy), 64'd0);

    // Store with req_ready held low for 4 cycles.
    strobe(1'b0, 1'b1, 32'h204, 32'h12345678);
    step(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check("st_req_valid", 64'(req_valid), 64'd1);
      check("st_req_addr", 64'(req_addr), 64'h204);
      check("st_req_wdata", 64'(req_wdata), 64'h12345678);
      check("st_req_we", 64'(req_we), 64'd1);
      if (i == 4) req_ready = 1'b1;
      step();
    end
    req_ready = 1'b0;
    check("st_valid_wait", 64'(req_valid), 64'd0);
    check("st_done_wait", 64'(mem_done), 64'd0);
    resp_valid = 1'b1; resp_rdata = 32'hCAFEF00D;
    step(); resp_valid = 1'b0;
    check("st_done", 64'(mem_done), 64'd1);
    check("st_err", 64'(mem_err), 64'd0);
    check("st_rdata_kept", 64'(rdata), 64'hDEADBEEF);
    step();
    check("st_done_once", 64'(mem_done), 64'd0);

    // No-op access completes one cycle after the strobe.
    strobe(1'b0, 1'b0, 32'h55, 32'h0);
    step(); idle_inputs();
    check("nop_done", 64'(mem_done), 64'd1);
    check("nop_err", 64'(mem_err), 64'd0);
    check("nop_valid", 64'(req_valid), 64'd0);
    step();
    check("nop_idle", 64'(mem_busy), 64'd0);
    check("nop_sticky", 64'(err_sticky), 64'd0);

    // Second strobe while a load is pending.
    strobe(1'b1, 1'b0, 32'h300, 32'h0);
    step();
    strobe(1'b0, 1'b1, 32'h400, 32'h99);
    req_ready = 1'b1;
    step(); idle_inputs(); req_ready = 1'b0;
    check("col_sticky", 64'(err_sticky), 64'd1);
    check("col_req_addr", 64'(req_addr), 64'h300);
    check("col_req_we", 64'(req_we), 64'd0);
    resp_valid = 1'b1; resp_rdata = 32'h0BADF00D;
    step(); resp_valid = 1'b0;
    check("col_done", 64'(mem_done), 64'd1);
    check("col_err", 64'(mem_err), 64'd0);
    check("col_rdata", 64'(rdata), 64'h0BADF00D);
    step();

    // Reset during WAIT_RESP.
    strobe(1'b1, 1'b0, 32'h500, 32'h0);
    step(); idle_inputs(); req_ready = 1'b1;
    step(); req_ready = 1'b0;
    check("rw_in_wait", 64'(req_valid), 64'd0);
    reset_n = 1'b0;
    step();
    check("rw_busy", 64'(mem_busy), 64'd0);
    check("rw_done", 64'(mem_done), 64'd0);
    check("rw_err", 64'(mem_err), 64'd0);
    check("rw_sticky", 64'(err_sticky), 64'd0);
    check("rw_rdata", 64'(rdata), 64'd0);
    check("rw_req_addr", 64'(req_addr), 64'd0);
    check("rw_req_valid", 64'(req_valid), 64'd0);
    reset_n = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h11111111;
    step(); resp_valid = 1'b0;
    check("late_resp_done", 64'(mem_done), 64'd0);
    check("late_resp_busy", 64'(mem_busy), 64'd0);
    check("late_resp_rdata", 64'(rdata), 64'd0);

    // Misaligned load aborts without a memory request.
    strobe(1'b1, 1'b0, 32'h103, 32'h0);
    step(); idle_inputs();
    check("mis_valid", 64'(req_valid), 64'd0);
    check("mis_done", 64'(mem_done), 64'd1);
    check("mis_err", 64'(mem_err), 64'd1);
    step();
    check("mis_done_off", 64'(mem_done), 64'd0);
    check("mis_sticky", 64'(err_sticky), 64'd1);
    step(); step();
    check("mis_sticky_hold", 64'(err_sticky), 64'd1);
    check("mis_rdata", 64'(rdata), 64'd0);

    // Load and store together is illegal.
    strobe(1'b1, 1'b1, 32'h600, 32'h0);
    step(); idle_inputs();
    check("ill_done", 64'(mem_done), 64'd1);
    check("ill_err", 64'(mem_err), 64'd1);
    check("ill_valid", 64'(req_valid), 64'd0);
    step();

    reset_n = 1'b0; step(); reset_n = 1'b1; step();

    // TIMEOUT=4: response arriving on the 4th counted cycle still completes.
    strobe(1'b1, 1'b0, 32'h700, 32'h0);
    step(); idle_inputs(); req_ready = 1'b1;
    step(); req_ready = 1'b0;
    step();
    step();
    check("t4_busy_c4", 64'(t_busy), 64'd1);
    resp_valid = 1'b1; resp_rdata = 32'hA5A5A5A5;
    step(); resp_valid = 1'b0;
    check("t4_done", 64'(t_done), 64'd1);
    check("t4_err", 64'(t_err), 64'd0);
    check("t4_rdata", 64'(t_rdata), 64'hA5A5A5A5);
    step();

    // TIMEOUT=4: no response aborts after the 4th counted cycle.
    strobe(1'b1, 1'b0, 32'h800, 32'h0);
    step(); idle_inputs(); req_ready = 1'b1;
    step(); req_ready = 1'b0;
    step();
    step();
    check("to_done_c4", 64'(t_done), 64'd0);
    step();
    check("to_done", 64'(t_done), 64'd1);
    check("to_err", 64'(t_err), 64'd1);
    check("to_rdata", 64'(t_rdata), 64'hA5A5A5A5);
    step();
    check("to_sticky", 64'(t_sticky), 64'd1);
    check("to_idle", 64'(t_busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Responder on the MEM-stage side of the multi-cycle stage controller. It accepts the one-cycle MEM enable strobe with a decoded load/store request and runs a valid/ready request plus response handshake to data memory. It captures load data and returns a one-cycle completion pulse and a busy level, so the controller can hold in its MEM stage until the access finishes. It also detects misaligned accesses and memory timeouts.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; word = DATA_W/8 bytes
TIMEOUT, 255, max cycles spent in REQ+WAIT_RESP before abort; 8-bit counter, legal range 1..255

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
mem_en  in  1  MEM stage strobe from stage controller, one cycle per access
is_load  in  1  access is a load; sampled with mem_en
is_store  in  1  access is a store; sampled with mem_en
addr  in  ADDR_W  byte address; sampled with mem_en
wdata  in  DATA_W  store data; sampled with mem_en
mem_busy  out  1  high while state != IDLE
mem_done  out  1  one-cycle completion pulse to controller
mem_err  out  1  pulses with mem_done when the access aborted
err_sticky  out  1  set on any error; cleared only by reset
rdata  out  DATA_W  last successfully loaded word
req_valid  out  1  memory request valid
req_ready  in  1  memory accepts request
req_we  out  1  1 = store, 0 = load
req_addr  out  ADDR_W  latched address
req_wdata  out  DATA_W  latched store data
resp_valid  in  1  memory response or store ack
resp_rdata  in  DATA_W  load data, valid with resp_valid

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Reset: state = IDLE. mem_busy, mem_done, mem_err, err_sticky, req_valid, req_we = 0. rdata, req_addr, req_wdata, timeout counter = 0. Reset takes effect in any state, including mid-handshake: req_valid drops the next cycle and no mem_done is issued.
- States: IDLE, REQ, WAIT_RESP, DONE, ERR.
- IDLE, mem_en=1:
  - is_load=is_store=0 (no memory op): go to DONE. mem_done appears 1 cycle after the strobe.
  - is_load=is_store=1: illegal; go to ERR.
  - addr[1:0] != 0 with a load or store: misaligned; go to ERR. No memory request is issued.
  - Otherwise: latch addr, wdata, and req_we=is_store; clear the counter; go to REQ.
- REQ: req_valid=1, with req_addr, req_wdata and req_we held stable.
  - req_valid & req_ready: go to WAIT_RESP.
- WAIT_RESP: req_valid=0.
  - resp_valid: if load, rdata <= resp_rdata. Go to DONE. Stores use resp_valid as an ack and leave rdata unchanged.
- Timeout: the counter increments every cycle in REQ or WAIT_RESP. When it equals TIMEOUT without the awaited handshake, go to ERR. If the handshake arrives in the same cycle the counter hits TIMEOUT, the handshake wins.
- DONE: mem_done=1 for exactly one cycle, then IDLE.
- ERR: mem_done=1 and mem_err=1 for one cycle, err_sticky <= 1, then IDLE. rdata is unchanged.
- mem_busy = (state != IDLE). It is high during DONE/ERR and falls the cycle after the mem_done pulse.
- mem_en while mem_busy=1: the request is ignored and err_sticky <= 1. The current access is unaffected.
- resp_valid outside WAIT_RESP: ignored (spurious).
- Nominal latency, with req_ready=1 and resp_valid the cycle after the handshake: strobe at cycle 0, REQ at 1, WAIT_RESP at 2, mem_done at 3.
- mem_done is never asserted in two consecutive cycles.

Test Plan:
- Reset, then load at addr=0x100: req_ready=1 in the REQ cycle; resp_valid with resp_rdata=0xDEADBEEF one cycle later. Expect req_addr=0x100 and req_we=0, mem_done at cycle 3, rdata=0xDEADBEEF, mem_err=0.
- Store at addr=0x204, wdata=0x12345678: req_ready held 0 for 4 cycles. Expect req_valid high and fields stable for 5 cycles. After the ack, mem_done pulses once and rdata keeps its prior value 0xDEADBEEF.
- Load at addr=0x103: expect no req_valid, mem_done=mem_err=1 one cycle after the strobe, err_sticky=1 until reset.
- TIMEOUT=4; load with req_ready=1 but resp_valid never asserted: expect ERR after 4 counted cycles, mem_err pulse, rdata unchanged. With resp_valid arriving exactly on the 4th cycle instead, expect a normal completion.
- mem_en with is_load=is_store=0: mem_done at +1 cycle and no memory request. A second mem_en during a pending load sets err_sticky; the pending load still completes with correct rdata.
- reset_n low during WAIT_RESP: the next cycle shows all outputs at reset values and no mem_done. A late resp_valid after reset is ignored.
